// File: rtl/hex_display_mux_if.sv
// Display bus between the datapath and the multiplexed 7-segment driver.
interface hex_display_mux_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   digit_en;
    logic                blank;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output value, load, dp_in, digit_en, blank,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, dp_in, digit_en, blank,
        output seg, dp, an
    );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode 7-segment driver: one digit per refresh slot,
// with dead time, blanking, per-digit enables and optional leading-zero suppression.
module hex_display_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD        = 1,
    parameter int unsigned LZ_SUPPRESS = 0
) (
    input logic              clk,
    input logic              reset,
    hex_display_mux_if.slave bus
);
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  val_q;
    logic [DIGITS-1:0] dp_q;
    logic [6:0]        seg_q;
    logic              dp_r;
    logic [DIGITS-1:0] an_q;

    logic              pre_last_c;
    logic              idx_last_c;
    logic [DIGITS-1:0] sel_c;
    logic [DIGITS-1:0] supp_c;
    logic              run;
    logic [3:0]        nib_c;
    logic              lit_c;
    logic [6:0]        seg_c;
    logic              dp_c;
    logic [DIGITS-1:0] an_c;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is suppressed when it and every digit to its left are zero with no dp lit
    always_comb begin
        supp_c = '0;
        run    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            run = run & (val_q[4*i +: 4] == 4'h0) & ~dp_q[i];
            if (i > 0 && LZ_SUPPRESS != 0) begin
                supp_c[i] = run;
            end
        end
    end

    // Select the current digit through a one-hot mask so the logic is uniform for any DIGITS
    always_comb begin
        pre_last_c = (pre == PRE_W'(REFRESH_DIV - 1));
        idx_last_c = (idx == IDX_W'(DIGITS - 1));
        sel_c      = DIGITS'(1) << idx;
        nib_c      = 4'(val_q >> (4 * 32'(idx)));
        lit_c      = (32'(pre) >= DEAD) && !bus.blank
                     && (|(bus.digit_en & sel_c)) && !(|(supp_c & sel_c));
        seg_c      = 7'h7F;
        dp_c       = 1'b1;
        an_c       = '1;
        if (lit_c) begin
            seg_c = hex7(nib_c);
            dp_c  = ~(|(dp_q & sel_c));
            an_c  = ~sel_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            idx   <= '0;
            val_q <= '0;
            dp_q  <= '0;
            seg_q <= 7'h7F;
            dp_r  <= 1'b1;
            an_q  <= '1;
        end else begin
            pre <= pre_last_c ? '0 : pre + PRE_W'(1);
            if (pre_last_c) begin
                idx <= idx_last_c ? '0 : idx + IDX_W'(1);
            end
            if (bus.load) begin
                val_q <= bus.value;
                dp_q  <= bus.dp_in;
            end
            seg_q <= seg_c;
            dp_r  <= dp_c;
            an_q  <= an_c;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_r;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux: directed stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_hex_display_mux;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] value4;
    logic        load;
    logic [3:0]  dp4;
    logic [3:0]  en4;
    logic        blank;

    always #5 clk = ~clk;

    hex_display_mux_if #(.DIGITS(4)) m_if ();
    hex_display_mux_if #(.DIGITS(4)) l_if ();
    hex_display_mux_if #(.DIGITS(1)) o_if ();

    assign m_if.value = value4;   assign m_if.load = load;   assign m_if.dp_in = dp4;
    assign m_if.digit_en = en4;   assign m_if.blank = blank;
    assign l_if.value = value4;   assign l_if.load = load;   assign l_if.dp_in = dp4;
    assign l_if.digit_en = en4;   assign l_if.blank = blank;
    assign o_if.value = value4[3:0]; assign o_if.load = load; assign o_if.dp_in = dp4[0:0];
    assign o_if.digit_en = en4[0:0]; assign o_if.blank = blank;

    hex_display_mux #(.DIGITS(4), .REFRESH_DIV(4), .DEAD(1), .LZ_SUPPRESS(0)) u_main (
        .clk(clk), .reset(reset), .bus(m_if));
    hex_display_mux #(.DIGITS(4), .REFRESH_DIV(4), .DEAD(1), .LZ_SUPPRESS(1)) u_lz (
        .clk(clk), .reset(reset), .bus(l_if));
    hex_display_mux #(.DIGITS(1), .REFRESH_DIV(4), .DEAD(1), .LZ_SUPPRESS(0)) u_one (
        .clk(clk), .reset(reset), .bus(o_if));

    typedef struct {
        int         cyc;
        int         sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation due at this cycle
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] a_an;
        logic [6:0] a_seg;
        logic       a_dp;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            case (e.sel)
                0:       begin a_an = m_if.an; a_seg = m_if.seg; a_dp = m_if.dp; end
                1:       begin a_an = l_if.an; a_seg = l_if.seg; a_dp = l_if.dp; end
                default: begin a_an = {3'b111, o_if.an}; a_seg = o_if.seg; a_dp = o_if.dp; end
            endcase
            n_vec++;
            if (e.cyc != cyc || a_an !== e.an || a_seg !== e.seg || a_dp !== e.dp) begin
                n_bad++;
                $display("FAIL %s dut=%0d cyc=%0d (due %0d): got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         e.name, e.sel, cyc, e.cyc, a_an, a_seg, a_dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic step(input int sel, input logic [3:0] an, input logic [6:0] seg,
                        input logic dp, input string name);
        sbq.push_back('{cyc + 1, sel, an, seg, dp, name});
        @(negedge clk);
    endtask

    // Reset for two cycles, then release with a load; returns at the negedge after the first counting edge
    task automatic start(input int sel, input logic [15:0] v, input logic [3:0] d);
        reset = 1'b1;
        load  = 1'b0;
        step(sel, 4'hF, 7'h7F, 1'b1, "reset_hold");
        step(sel, 4'hF, 7'h7F, 1'b1, "reset_hold");
        reset  = 1'b0;
        load   = 1'b1;
        value4 = v;
        dp4    = d;
        step(sel, 4'hF, 7'h7F, 1'b1, "first_dead");
        load = 1'b0;
    endtask

    // Expected scan for a 4-digit DUT, k counted in cycles from the reset release negedge
    task automatic scan(input int sel, input int kfrom, input int kto, input logic [3:0] darkm,
                        input logic [3:0][6:0] segs, input logic [3:0] dpm, input string name);
        int slot;
        int pos;
        for (int k = kfrom; k <= kto; k++) begin
            slot = ((k - 1) / 4) % 4;
            pos  = (k - 1) % 4;
            if (pos == 0 || darkm[slot])
                step(sel, 4'hF, 7'h7F, 1'b1, name);
            else
                step(sel, ~(4'b0001 << slot), segs[slot], ~dpm[slot], name);
        end
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        value4 = '0;
        dp4    = '0;
        en4    = 4'hF;
        blank  = 1'b0;
        @(negedge clk);

        // Reset and basic scan of 12AF
        start(0, 16'h12AF, 4'h0);
        scan(0, 2, 20, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "scan_12AF");

        // Decode sweep on the single-digit instance, one nibble per slot
        start(2, 16'h0000, 4'h0);
        for (int k = 2; k <= 4; k++) step(2, 4'hE, 7'h40, 1'b1, "decode_0");
        for (int n = 1; n < 16; n++) begin
            value4 = 16'(n);
            load   = 1'b1;
            step(2, 4'hF, 7'h7F, 1'b1, "decode_dead");
            load = 1'b0;
            for (int k = 0; k < 3; k++) step(2, 4'hE, dec_tab[n], 1'b1, $sformatf("decode_%h", n));
        end

        // Leading-zero suppression
        start(1, 16'h0030, 4'h0);
        scan(1, 2, 16, 4'b1100, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'h0, "lz_0030");
        start(1, 16'h0000, 4'h0);
        scan(1, 2, 16, 4'b1110, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h0, "lz_0000");
        start(1, 16'h0030, 4'b0100);
        scan(1, 2, 16, 4'b1000, {7'h7F, 7'h40, 7'h30, 7'h40}, 4'b0100, "lz_dp2");

        // Digit enable mask
        en4 = 4'b1010;
        start(0, 16'h12AF, 4'h0);
        scan(0, 2, 16, 4'b0101, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "digit_en");
        en4 = 4'hF;

        // Blank mid-slot then release
        start(0, 16'h12AF, 4'h0);
        scan(0, 2, 2, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "pre_blank");
        blank = 1'b1;
        step(0, 4'hF, 7'h7F, 1'b1, "blank_on");
        blank = 1'b0;
        step(0, 4'hE, 7'h0E, 1'b1, "blank_off");
        scan(0, 5, 8, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "post_blank");

        // Load hold, async reset at pre=2, restart at digit 0
        start(0, 16'h12AF, 4'h0);
        scan(0, 2, 2, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "hold_pre");
        value4 = 16'h0000;
        scan(0, 3, 5, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "load_hold");
        sbq.push_back('{cyc + 1, 0, 4'hF, 7'h7F, 1'b1, "async_reset"});
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        step(0, 4'hF, 7'h7F, 1'b1, "reset_held");
        start(0, 16'h12AF, 4'h0);
        scan(0, 2, 8, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, "restart");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            $display("FAIL drain: %0d expectations never compared, expected 0", sbq.size());
            n_bad += sbq.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
